seg_dynamic_bcd: RTL and testbench

Six-digit multiplexed seven-segment driver that sits directly upstream of the 74HC595 serializer (`hc595_ctrl`). It replaces the fixed-digit static source with a live display.

- It takes a 20-bit binary value, decimal-point mask, sign flag and enable.
- It converts the value to BCD with a sequential shift-add-3 converter and applies leading-zero blanking and sign placement.
- It scans one digit per millisecond on `sel`/`seg`, in the exact format `hc595_ctrl` consumes.

---
 rtl/seg_dynamic_bcd_if.sv | 12 +
 rtl/seg_dynamic_bcd.sv | 159 +++++++++++++++
 tb/tb_seg_dynamic_bcd.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seg_dynamic_bcd_if.sv
// Display-side bundle between the value source and the six-digit scan driver.
interface seg_dynamic_bcd_if;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  modport master (output data, point, sign, seg_en, input sel, seg);
  modport slave  (input data, point, sign, seg_en, output sel, seg);
endinterface

// File: rtl/seg_dynamic_bcd.sv
// Six-digit multiplexed seven-segment driver: free-running binary-to-BCD
// converter, leading-zero blanking with sign placement, 1 ms digit scan.
module seg_dynamic_bcd #(
  parameter logic [15:0] CNT_1MS_MAX = 16'd49_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  seg_dynamic_bcd_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [19:0] bin;
  logic [23:0] bcd;
  logic [23:0] bcd_adj;
  logic [4:0]  bit_cnt;
  logic [5:0]  cap_point;
  logic        cap_sign;
  logic [19:0] data_clamped;

  logic [23:0] disp_bcd;
  logic [5:0]  disp_point;
  logic        disp_sign;

  logic [15:0] scan_cnt;
  logic [2:0]  idx;
  logic [2:0]  m, p, k;
  logic [3:0]  digit;
  logic [5:0]  sel_nxt;
  logic [7:0]  seg_nxt;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 8'hC0;
      4'd1: glyph = 8'hF9;
      4'd2: glyph = 8'hA4;
      4'd3: glyph = 8'hB0;
      4'd4: glyph = 8'h99;
      4'd5: glyph = 8'h92;
      4'd6: glyph = 8'h82;
      4'd7: glyph = 8'hF8;
      4'd8: glyph = 8'h80;
      4'd9: glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  always_comb begin
    data_clamped = (bus.data > 20'd999_999) ? 20'd999_999 : bus.data;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 5'd19) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bin        <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      cap_point  <= '0;
      cap_sign   <= 1'b0;
      disp_bcd   <= '0;
      disp_point <= '0;
      disp_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bin       <= data_clamped;
          cap_point <= bus.point;
          cap_sign  <= bus.sign;
          bcd       <= '0;
          bit_cnt   <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
          bit_cnt    <= bit_cnt + 5'd1;
        end
        DONE: begin
          disp_bcd   <= bcd;
          disp_point <= cap_point;
          disp_sign  <= cap_sign;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_1MS_MAX) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // k is the leftmost shown digit: highest of the top nonzero digit and top dp.
  always_comb begin
    m = '0;
    p = '0;
    for (int unsigned i = 1; i < 6; i++) begin
      if (disp_bcd[i*4 +: 4] != 4'd0) m = 3'(i);
      if (disp_point[i])               p = 3'(i);
    end
    k = (m > p) ? m : p;
  end

  always_comb begin
    digit = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (idx == 3'(i)) digit = disp_bcd[i*4 +: 4];
    end
    sel_nxt = 6'b000001 << idx;
    seg_nxt = 8'hFF;
    if (idx == 3'd0 || idx <= k) begin
      seg_nxt = glyph(digit);
      if (disp_point[idx]) seg_nxt[7] = 1'b0;
    end else if (disp_sign && k < 3'd5 && idx == k + 3'd1) begin
      seg_nxt = 8'hBF;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bus.sel <= '0;
      bus.seg <= 8'hFF;
    end else if (!bus.seg_en) begin
      bus.sel <= '0;
      bus.seg <= 8'hFF;
    end else begin
      bus.sel <= sel_nxt;
      bus.seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_bcd.sv
// Directed-vector bench for the six-digit BCD scan driver (CNT_1MS_MAX = 4).
module tb_seg_dynamic_bcd;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  seg_dynamic_bcd_if bus ();

  seg_dynamic_bcd #(.CNT_1MS_MAX(16'd4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [19:0]     data;
    logic [5:0]      point;
    logic            sign;
    logic [5:0][7:0] exp;   // exp[i] is the glyph of digit i
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wait_sel(input logic [5:0] target, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge sys_clk);
      if (bus.sel === target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_frame(input logic [5:0][7:0] exp, input string name);
    bit ok;
    logic [5:0] tgt;
    for (int d = 0; d < 6; d++) begin
      tgt = 6'b000001 << d;
      wait_sel(tgt, 40, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL %s digit %0d: sel never reached %b (last %b)", name, d, tgt, bus.sel);
      end else begin
        check8($sformatf("%s digit %0d", name, d), bus.seg, exp[d]);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    bus.data  = v.data;
    bus.point = v.point;
    bus.sign  = v.sign;
  endtask

  initial begin
    bit ok;
    int n;

    vecs[0]  = '{20'd123456,  6'b000000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
    vecs[1]  = '{20'd5,       6'b000100, 1'b1, {8'hFF, 8'hFF, 8'hBF, 8'h40, 8'hC0, 8'h92}};
    vecs[2]  = '{20'hFFFFF,   6'b000000, 1'b1, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[3]  = '{20'd0,       6'b000000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[4]  = '{20'd0,       6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0}};
    vecs[5]  = '{20'd999999,  6'b100001, 1'b0, {8'h10, 8'h90, 8'h90, 8'h90, 8'h90, 8'h10}};
    vecs[6]  = '{20'd1000000, 6'b000000, 1'b1, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[7]  = '{20'd42,      6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4}};
    vecs[8]  = '{20'd7,       6'b100000, 1'b1, {8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF8}};
    vecs[9]  = '{20'd100,     6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hBF, 8'hF9, 8'hC0, 8'hC0}};
    vecs[10] = '{20'd50000,   6'b000010, 1'b0, {8'hFF, 8'h92, 8'hC0, 8'hC0, 8'h40, 8'hC0}};

    // Reset and first edge after release
    bus.data = '0; bus.point = '0; bus.sign = 1'b0; bus.seg_en = 1'b1;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check6("reset_sel", bus.sel, 6'b000000);
    check8("reset_seg", bus.seg, 8'hFF);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check6("first_sel", bus.sel, 6'b000001);
    check8("first_seg", bus.seg, 8'hC0);
    check_frame(vecs[3].exp, "reset_frame");

    // Digit dwell: CNT_1MS_MAX+1 = 5 cycles per digit
    wait_sel(6'b000001, 40, ok);
    if (ok) wait_sel(6'b000010, 40, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL dwell_sync: sel %b never reached digit1", bus.sel);
    end else begin
      n = 1;
      while (n < 20) begin
        @(negedge sys_clk);
        if (bus.sel !== 6'b000010) break;
        n++;
      end
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL dwell: got %0d cycles, expected 5", n);
      end
    end

    // Table of values
    for (int v = 0; v < NVEC; v++) begin
      apply(vecs[v]);
      repeat (50) @(negedge sys_clk);
      check_frame(vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Display off for exactly one frame period, resumes on the same digit
    apply(vecs[0]);
    repeat (50) @(negedge sys_clk);
    wait_sel(6'b000010, 40, ok);
    if (ok) wait_sel(6'b000100, 40, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL off_sync: sel %b never reached digit2", bus.sel);
    end else begin
      bus.seg_en = 1'b0;
      @(posedge sys_clk); #1;
      check6("off_sel", bus.sel, 6'b000000);
      check8("off_seg", bus.seg, 8'hFF);
      repeat (30) @(negedge sys_clk);
      check6("off_hold_sel", bus.sel, 6'b000000);
      bus.seg_en = 1'b1;
      @(posedge sys_clk); #1;
      check6("resume_sel", bus.sel, 6'b000100);
      check8("resume_seg", bus.seg, 8'h99);
    end

    // Reset mid-conversion with a nonzero value already displayed
    @(negedge sys_clk);
    apply(vecs[5]);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;                      // IDLE captures at edges 1, 23, 45, 67
    repeat (50) @(negedge sys_clk);
    bus.data = 20'd654321; bus.point = '0; bus.sign = 1'b0;
    repeat (16) @(negedge sys_clk);      // just after edge 66
    repeat (11) @(negedge sys_clk);      // shift counter at 10
    sys_rst = 1'b1;
    #1;
    check6("midrst_sel", bus.sel, 6'b000000);
    check8("midrst_seg", bus.seg, 8'hFF);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check6("midrst_first_sel", bus.sel, 6'b000001);
    check8("midrst_first_seg", bus.seg, 8'hC0);
    repeat (45) @(negedge sys_clk);
    check_frame({8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9}, "midrst_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
